// File: rtl/colors_to_bytes.sv
// -----------------------------------------------------------------------------
// colors_to_bytes
//
// Packs a stream of 12-bit colour words into an 8-bit bytestream. Every two
// colours become three bytes, with the first colour's nibbles going out first.
// An odd trailing colour is padded with a zero nibble. The done pulse comes
// out with the final byte, or on its own if nothing is buffered.
//
// Ports:
//   clk            in   clock
//   reset          in   synchronous, active-high reset
//   inclk          in   one-cycle strobe: a colour is on `in`
//   in             in   colour word (COLOR_LEN bits)
//   in_done        in   end of stream (with the last inclk or on its own)
//   downstream_rdy in   consumer can take a byte this cycle
//   rdy            out  combinational: a colour can be accepted this cycle
//   outclk         out  registered strobe: a byte is on `out`
//   out            out  registered byte (BYTE_LEN bits)
//   done           out  registered single-cycle end-of-stream pulse
//   overflow       out  registered sticky flag: a colour arrived while rdy=0
// -----------------------------------------------------------------------------
module colors_to_bytes #(
    parameter int COLOR_LEN = 12,
    parameter int BYTE_LEN  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inclk,
    input  logic [COLOR_LEN-1:0] in,
    input  logic                 in_done,
    input  logic                 downstream_rdy,
    output logic                 rdy,
    output logic                 outclk,
    output logic [BYTE_LEN-1:0]  out,
    output logic                 done,
    output logic                 overflow
);

    // Nibble buffer, left-justified: the oldest nibble sits in [23:20].
    // Bits below the fill level are kept at zero, so padding an odd
    // colour only needs a fill increment.
    logic [23:0]         data_q,     data_d;
    logic [2:0]          fill_q,     fill_d;
    logic                pend_q,     pend_d;
    logic                outclk_q,   outclk_d;
    logic [BYTE_LEN-1:0] out_q,      out_d;
    logic                done_q,     done_d;
    logic                overflow_q, overflow_d;

    logic                emit_s;
    logic                accept_s;
    logic [23:0]         shifted_s;
    logic [2:0]          fill_base_s;
    logic [23:0]         insert_s;

    // A colour is taken only when at most three nibbles remain, so the
    // buffer can never exceed six nibbles.
    assign rdy      = !reset && !pend_q && (fill_q <= 3'd3);
    assign accept_s = inclk && rdy;
    assign emit_s   = (fill_q >= 3'd2) && downstream_rdy;

    assign outclk   = outclk_q;
    assign out      = out_q;
    assign done     = done_q;
    assign overflow = overflow_q;

    // Next-state: emission shift, colour append, odd padding, end-of-stream.
    always_comb begin
        data_d      = data_q;
        fill_d      = fill_q;
        pend_d      = pend_q;
        outclk_d    = 1'b0;
        out_d       = out_q;
        done_d      = 1'b0;
        overflow_d  = overflow_q | (inclk & ~rdy);

        // Apply any emission first; an accepted colour lands after it.
        if (emit_s) begin
            shifted_s   = {data_q[15:0], 8'h00};
            fill_base_s = fill_q - 3'd2;
            outclk_d    = 1'b1;
            out_d       = data_q[23:16];
        end else begin
            shifted_s   = data_q;
            fill_base_s = fill_q;
        end

        insert_s = {in, 12'h000} >> {fill_base_s, 2'b00};

        if (accept_s) begin
            data_d = shifted_s | insert_s;
            fill_d = fill_base_s + 3'd3;
        end else if (pend_q && (fill_q == 3'd1)) begin
            // Odd colour count: the zero nibble below is already in place.
            data_d = data_q;
            fill_d = 3'd2;
        end else begin
            data_d = shifted_s;
            fill_d = fill_base_s;
        end

        // End-of-stream: done rides with the byte that empties the buffer,
        // or goes out alone when the buffer is already empty.
        if (pend_q) begin
            if (emit_s && (fill_q == 3'd2)) begin
                done_d = 1'b1;
                pend_d = 1'b0;
            end else if (fill_q == 3'd0) begin
                done_d = 1'b1;
                pend_d = 1'b0;
            end else begin
                pend_d = 1'b1;
            end
        end else if (in_done) begin
            pend_d = 1'b1;
        end else begin
            pend_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= 24'h000000;
            fill_q     <= 3'd0;
            pend_q     <= 1'b0;
            outclk_q   <= 1'b0;
            out_q      <= {BYTE_LEN{1'b0}};
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            data_q     <= data_d;
            fill_q     <= fill_d;
            pend_q     <= pend_d;
            outclk_q   <= outclk_d;
            out_q      <= out_d;
            done_q     <= done_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: tb/tb_colors_to_bytes.sv
// -----------------------------------------------------------------------------
// tb_colors_to_bytes
//
// Self-checking bench for colors_to_bytes. A negedge monitor records every
// byte (with its done flag), lone done pulses and any byte that follows a
// cycle with downstream_rdy low. Expected byte streams come from constants
// or from a nibble-list model of the colours actually sent.
// -----------------------------------------------------------------------------
module tb_colors_to_bytes;

    logic        clk = 1'b0;
    logic        reset;
    logic        inclk;
    logic [11:0] in_c;
    logic        in_done;
    logic        downstream_rdy;
    logic        rdy;
    logic        outclk;
    logic [7:0]  out_b;
    logic        done;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    logic [7:0]  got_bytes[$];
    bit          got_done[$];
    int          done_alone  = 0;
    int          done_events = 0;
    int          bp_viol     = 0;
    logic        ds_at_edge  = 1'b0;

    logic [11:0] sent[$];
    logic [7:0]  exp_q[$];
    bit          rdy_waited;
    bit          bp_run;

    colors_to_bytes #(.COLOR_LEN(12), .BYTE_LEN(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .inclk          (inclk),
        .in             (in_c),
        .in_done        (in_done),
        .downstream_rdy (downstream_rdy),
        .rdy            (rdy),
        .outclk         (outclk),
        .out            (out_b),
        .done           (done),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    // Remember downstream_rdy as sampled by each rising edge.
    always @(posedge clk) ds_at_edge <= downstream_rdy;

    // Output monitor.
    always @(negedge clk) begin
        if (!reset) begin
            if (outclk) begin
                got_bytes.push_back(out_b);
                got_done.push_back(done);
                if (!ds_at_edge) bp_viol <= bp_viol + 1;
            end else if (done) begin
                done_alone <= done_alone + 1;
            end
            if (done) done_events <= done_events + 1;
        end
    end

    // Model: colours become a nibble list, padded to even, read two at a time.
    function automatic void build_expected();
        logic [3:0] nib[$];
        exp_q.delete();
        foreach (sent[i]) begin
            nib.push_back(sent[i][11:8]);
            nib.push_back(sent[i][7:4]);
            nib.push_back(sent[i][3:0]);
        end
        if (nib.size() % 2 == 1) nib.push_back(4'h0);
        for (int i = 0; i < nib.size(); i += 2) exp_q.push_back({nib[i], nib[i+1]});
    endfunction

    task automatic send(input logic [11:0] c, input logic last);
        int t = 0;
        while (!rdy && t < 50) begin
            rdy_waited = 1'b1;
            @(posedge clk); #1;
            t++;
        end
        if (t >= 50) begin
            errors++;
            $display("FAIL send_timeout: rdy=%b required 1", rdy);
        end
        inclk = 1'b1; in_c = c; in_done = last;
        sent.push_back(c);
        @(posedge clk); #1;
        inclk = 1'b0; in_done = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int start = done_events;
        int t = 0;
        while (done_events == start && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (done_events == start) begin
            errors++;
            $display("FAIL %s_done_timeout: done events=%0d required >%0d", name, done_events, start);
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; inclk = 1'b0; in_c = 12'h000; in_done = 1'b0; downstream_rdy = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (outclk !== 1'b0)   begin errors++; $display("FAIL reset_outclk: got %b required 0", outclk); end
        checks++; if (out_b !== 8'h00)    begin errors++; $display("FAIL reset_out: got %h required 00", out_b); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL reset_done: got %b required 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b required 0", overflow); end
        checks++; if (rdy !== 1'b0)      begin errors++; $display("FAIL reset_rdy_low: got %b required 0", rdy); end
        @(posedge clk); #1; reset = 1'b0;
        @(negedge clk);
        checks++; if (rdy !== 1'b1)      begin errors++; $display("FAIL reset_rdy_high: got %b required 1", rdy); end
    endtask

    task automatic test_two_colour();
        int b0 = got_bytes.size();
        exp_q = '{8'hAB, 8'hCD, 8'hEF};
        downstream_rdy = 1'b1;
        send(12'hABC, 1'b0);
        send(12'hDEF, 1'b1);
        wait_done("two");
        checks++; if (got_bytes.size() - b0 != exp_q.size()) begin errors++; $display("FAIL two_count: got %0d required %0d", got_bytes.size() - b0, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) if (b0 + i < got_bytes.size()) begin
            checks++; if (got_bytes[b0+i] !== exp_q[i]) begin errors++; $display("FAIL two_byte%0d: got %h required %h", i, got_bytes[b0+i], exp_q[i]); end
            checks++; if (got_done[b0+i] != (i == exp_q.size() - 1)) begin errors++; $display("FAIL two_done%0d: got %b required %b", i, got_done[b0+i], i == exp_q.size() - 1); end
        end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL two_overflow: got %b required 0", overflow); end
    endtask

    task automatic test_odd();
        int b0 = got_bytes.size();
        int a0 = done_alone;
        exp_q = '{8'h12, 8'h30};
        send(12'h123, 1'b1);
        wait_done("odd");
        checks++; if (got_bytes.size() - b0 != 2) begin errors++; $display("FAIL odd_count: got %0d required 2", got_bytes.size() - b0); end
        for (int i = 0; i < exp_q.size(); i++) if (b0 + i < got_bytes.size()) begin
            checks++; if (got_bytes[b0+i] !== exp_q[i]) begin errors++; $display("FAIL odd_byte%0d: got %h required %h", i, got_bytes[b0+i], exp_q[i]); end
            checks++; if (got_done[b0+i] != (i == 1)) begin errors++; $display("FAIL odd_done%0d: got %b required %b", i, got_done[b0+i], i == 1); end
        end
        checks++; if (done_alone != a0) begin errors++; $display("FAIL odd_lone_done: got %0d required %0d", done_alone, a0); end
    endtask

    task automatic test_backpressure();
        int b0 = got_bytes.size();
        int v0 = bp_viol;
        logic [3:0] pat;
        pat = 4'b1001;
        exp_q = '{8'h11, 8'h12, 8'h22, 8'h33, 8'h34, 8'h44};
        rdy_waited = 1'b0;
        bp_run = 1'b1;
        fork
            begin
                int k = 0;
                while (bp_run) begin
                    @(posedge clk); #1;
                    downstream_rdy = pat[k % 4];
                    k++;
                end
            end
        join_none
        send(12'h111, 1'b0);
        send(12'h222, 1'b0);
        send(12'h333, 1'b0);
        send(12'h444, 1'b1);
        wait_done("bp");
        bp_run = 1'b0;
        repeat (3) @(posedge clk);
        #1 downstream_rdy = 1'b1;
        checks++; if (got_bytes.size() - b0 != exp_q.size()) begin errors++; $display("FAIL bp_count: got %0d required %0d", got_bytes.size() - b0, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) if (b0 + i < got_bytes.size()) begin
            checks++; if (got_bytes[b0+i] !== exp_q[i]) begin errors++; $display("FAIL bp_byte%0d: got %h required %h", i, got_bytes[b0+i], exp_q[i]); end
        end
        checks++; if (bp_viol != v0)   begin errors++; $display("FAIL bp_stall: bytes after stalled edge got %0d required 0", bp_viol - v0); end
        checks++; if (!rdy_waited)     begin errors++; $display("FAIL bp_rdy_low: got never-low required low once"); end
    endtask

    task automatic test_back_to_back();
        int b0 = got_bytes.size();
        downstream_rdy = 1'b1;
        sent.delete();
        rdy_waited = 1'b0;
        for (int i = 0; i < 10; i++) send(12'($urandom), i == 9);
        build_expected();
        wait_done("b2b");
        checks++; if (got_bytes.size() - b0 != 15) begin errors++; $display("FAIL b2b_count: got %0d required 15", got_bytes.size() - b0); end
        for (int i = 0; i < exp_q.size(); i++) if (b0 + i < got_bytes.size()) begin
            checks++; if (got_bytes[b0+i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d: got %h required %h", i, got_bytes[b0+i], exp_q[i]); end
            checks++; if (got_done[b0+i] != (i == exp_q.size() - 1)) begin errors++; $display("FAIL b2b_done%0d: got %b required %b", i, got_done[b0+i], i == exp_q.size() - 1); end
        end
        checks++; if (!rdy_waited)       begin errors++; $display("FAIL b2b_rdy_low: got never-low required low once"); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b required 0", overflow); end
    endtask

    task automatic test_overflow();
        int b0 = got_bytes.size();
        int a0;
        downstream_rdy = 1'b0;
        sent.delete();
        send(12'($urandom), 1'b0);
        send(12'($urandom), 1'b0);
        build_expected();
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL ovf_rdy: got %b required 0", rdy); end
        inclk = 1'b1; in_c = 12'hBAD;
        @(posedge clk); #1; inclk = 1'b0;
        @(negedge clk);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b required 1", overflow); end
        @(posedge clk); #1;
        downstream_rdy = 1'b1; in_done = 1'b1;
        @(posedge clk); #1; in_done = 1'b0;
        wait_done("ovf");
        checks++; if (got_bytes.size() - b0 != exp_q.size()) begin errors++; $display("FAIL ovf_count: got %0d required %0d", got_bytes.size() - b0, exp_q.size()); end
        for (int i = 0; i < exp_q.size(); i++) if (b0 + i < got_bytes.size()) begin
            checks++; if (got_bytes[b0+i] !== exp_q[i]) begin errors++; $display("FAIL ovf_byte%0d: got %h required %h", i, got_bytes[b0+i], exp_q[i]); end
        end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b required 1", overflow); end
        // Lone in_done with an empty buffer.
        a0 = done_alone;
        @(posedge clk); #1; in_done = 1'b1;
        @(posedge clk); #1; in_done = 1'b0;
        @(negedge clk);
        checks++; if (done !== 1'b0 || outclk !== 1'b0) begin errors++; $display("FAIL empty_early: done=%b outclk=%b required 0 0", done, outclk); end
        @(negedge clk);
        checks++; if (done !== 1'b1 || outclk !== 1'b0) begin errors++; $display("FAIL empty_pulse: done=%b outclk=%b required 1 0", done, outclk); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL empty_single: done=%b required 0", done); end
        checks++; if (done_alone != a0 + 1) begin errors++; $display("FAIL empty_count: got %0d required %0d", done_alone - a0, 1); end
    endtask

    task automatic test_reset_mid();
        int b0;
        downstream_rdy = 1'b1;
        send(12'h5A5, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checks++; if (outclk !== 1'b0)   begin errors++; $display("FAIL rmid_outclk: got %b required 0", outclk); end
        checks++; if (done !== 1'b0)     begin errors++; $display("FAIL rmid_done: got %b required 0", done); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rmid_overflow: got %b required 0", overflow); end
        b0 = got_bytes.size();
        sent.delete();
        send(12'h9C3, 1'b0);
        send(12'h7E1, 1'b1);
        build_expected();
        wait_done("rmid");
        checks++; if (got_bytes.size() - b0 != 3) begin errors++; $display("FAIL rmid_count: got %0d required 3", got_bytes.size() - b0); end
        for (int i = 0; i < exp_q.size(); i++) if (b0 + i < got_bytes.size()) begin
            checks++; if (got_bytes[b0+i] !== exp_q[i]) begin errors++; $display("FAIL rmid_byte%0d: got %h required %h", i, got_bytes[b0+i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_two_colour();
        test_odd();
        test_backpressure();
        test_back_to_back();
        test_overflow();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
